uart_word_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 16 +
 rtl/word_fifo.sv | 53 +++++
 rtl/uart_word_tx.sv | 152 +++++++++++++++
 tb/tb_uart_word_tx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the board link: FSM states and 8N1 framing constants.
// The instruction loader's receiver imports this package as well.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;
    localparam int   UART_DATA_BITS = 8;

endpackage

// File: rtl/word_fifo.sv
// Small synchronous word FIFO with occupancy count; pointers wrap modulo DEPTH.
// Push while full and pop while empty are ignored internally.
module word_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Full is derived from the count alone, so a same-cycle pop never frees a slot early.
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // NOTE: the storage array is not reset; the reset count and pointers make stale entries unreachable.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/uart_word_tx.sv
// Word-oriented UART transmitter: queues 16-bit words and sends each as two 8N1 frames,
// high byte first, with no idle gap between frames or between queued words.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic        UART_RXD_OUT,
    output logic        busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam int QW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

    uart_state_t r_state;
    uart_state_t w_state_n;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_n;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_n;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] w_shift_n;
    logic [UART_DATA_BITS-1:0] r_low;
    logic [UART_DATA_BITS-1:0] w_low_n;
    logic r_byte_sel;
    logic w_byte_sel_n;
    logic r_line;
    logic w_line_n;

    logic          w_pop;
    logic          w_bit_done;
    logic [15:0]   w_head;
    logic          w_full;
    logic          w_empty;
    logic [QW-1:0] w_count;

    word_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (data_valid),
        .i_data  (data_in),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign data_ready   = !w_full;
    assign busy         = (w_count != '0) || (r_state != ST_IDLE);
    assign UART_RXD_OUT = r_line;
    assign w_bit_done   = (r_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_low      <= '0;
            r_byte_sel <= 1'b0;
            r_line     <= UART_STOP_BIT;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_idx      <= w_idx_n;
            r_shift    <= w_shift_n;
            r_low      <= w_low_n;
            r_byte_sel <= w_byte_sel_n;
            r_line     <= w_line_n;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt + CW'(1);
        w_idx_n      = r_idx;
        w_shift_n    = r_shift;
        w_low_n      = r_low;
        w_byte_sel_n = r_byte_sel;
        w_pop        = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_cnt_n = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_n    = w_head[15:8];
                    w_low_n      = w_head[7:0];
                    w_byte_sel_n = 1'b0;
                    w_state_n    = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_done) begin
                    w_cnt_n   = '0;
                    w_idx_n   = '0;
                    w_state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    w_cnt_n   = '0;
                    w_shift_n = r_shift >> 1;
                    w_idx_n   = r_idx + IW'(1);
                    if (r_idx == IDX_LAST) w_state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_done) begin
                    w_cnt_n = '0;
                    if (!r_byte_sel) begin
                        w_shift_n    = r_low;
                        w_byte_sel_n = 1'b1;
                        w_state_n    = ST_START;
                    end else if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_n    = w_head[15:8];
                        w_low_n      = w_head[7:0];
                        w_byte_sel_n = 1'b0;
                        w_state_n    = ST_START;
                    end else begin
                        w_state_n = ST_IDLE;
                    end
                end
            end
            default: w_state_n = ST_IDLE;
        endcase

        // The line is registered from next-state values so it changes on the same edge as the FSM.
        unique case (w_state_n)
            ST_START: w_line_n = UART_START_BIT;
            ST_DATA:  w_line_n = w_shift_n[0];
            default:  w_line_n = UART_STOP_BIT;
        endcase
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4; line checked cycle by cycle
// against a bit-timing model of back-to-back 8N1 frames.
module tb_uart_word_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int WORD_CYCLES = 20 * CPB;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] data_in = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic        UART_RXD_OUT;
    logic        busy;

    int checks = 0;
    int errors = 0;

    uart_word_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .UART_RXD_OUT (UART_RXD_OUT),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    // Expected line level k cycles after the start bit of word w begins.
    function automatic logic exp_line(input logic [15:0] w, input int k);
        int frame;
        int pos;
        logic [7:0] b;
        frame = k / (10 * CPB);
        pos   = (k % (10 * CPB)) / CPB;
        b     = (frame == 0) ? w[15:8] : w[7:0];
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[pos-1];
    endfunction

    task automatic test_reset();
        RST = 1'b1;
        data_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            checks++;
            if (UART_RXD_OUT !== 1'b1 || data_ready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset c=%0d line=%b ready=%b busy=%b, want line=1 ready=1 busy=0",
                         c, UART_RXD_OUT, data_ready, busy);
            end
        end
        RST = 1'b0;
        @(negedge CLK);
        checks++;
        if (UART_RXD_OUT !== 1'b1 || data_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset line=%b ready=%b busy=%b, want 1 1 0", UART_RXD_OUT, data_ready, busy);
        end
    endtask

    task automatic test_single_word(input logic [15:0] w);
        logic exp;
        @(negedge CLK);
        data_valid = 1'b1;
        data_in    = w;
        for (int t = 1; t <= WORD_CYCLES + 2; t++) begin
            @(negedge CLK);
            exp = (t >= 2 && t <= WORD_CYCLES + 1) ? exp_line(w, t - 2) : 1'b1;
            checks++;
            if (UART_RXD_OUT !== exp) begin
                errors++;
                $display("FAIL single_line w=%h t=%0d got %b want %b", w, t, UART_RXD_OUT, exp);
            end
            if (t >= WORD_CYCLES + 1) begin
                exp = (t == WORD_CYCLES + 1);
                checks++;
                if (busy !== exp) begin
                    errors++;
                    $display("FAIL single_busy w=%h t=%0d got %b want %b", w, t, busy, exp);
                end
            end
            data_valid = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        logic exp;
        localparam int LAST = 5 * WORD_CYCLES + 2;
        @(negedge CLK);
        data_valid = 1'b1;
        data_in    = 16'd1;
        for (int t = 1; t <= LAST; t++) begin
            @(negedge CLK);
            if (t >= 2) begin
                exp = (t <= LAST - 1) ? exp_line(16'((t - 2) / WORD_CYCLES + 1), (t - 2) % WORD_CYCLES) : 1'b1;
                checks++;
                if (UART_RXD_OUT !== exp) begin
                    errors++;
                    $display("FAIL bp_line t=%0d got %b want %b", t, UART_RXD_OUT, exp);
                end
            end
            if (t <= 20 || t == WORD_CYCLES + 1 || t == WORD_CYCLES + 2) begin
                exp = (t <= 4 || t == WORD_CYCLES + 2);
                checks++;
                if (data_ready !== exp) begin
                    errors++;
                    $display("FAIL bp_ready t=%0d got %b want %b", t, data_ready, exp);
                end
            end
            if (t >= LAST - 1) begin
                exp = (t == LAST - 1);
                checks++;
                if (busy !== exp) begin
                    errors++;
                    $display("FAIL bp_busy t=%0d got %b want %b", t, busy, exp);
                end
            end
            if (t < 6)       data_in = 16'(t + 1);
            else if (t < 20) data_in = 16'hDEAD;
            else             data_valid = 1'b0;
        end
    endtask

    task automatic test_reset_midframe();
        logic exp;
        @(negedge CLK);
        data_valid = 1'b1;
        data_in    = 16'h1234;
        for (int t = 1; t <= 40; t++) begin
            @(negedge CLK);
            if (t >= 2 && t <= 18) begin
                exp = exp_line(16'h1234, t - 2);
                checks++;
                if (UART_RXD_OUT !== exp || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL mid_pre t=%0d line=%b busy=%b, want line=%b busy=1", t, UART_RXD_OUT, busy, exp);
                end
            end
            if (t >= 19) begin
                checks++;
                if (UART_RXD_OUT !== 1'b1 || busy !== 1'b0 || data_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL mid_post t=%0d line=%b busy=%b ready=%b, want 1 0 1",
                             t, UART_RXD_OUT, busy, data_ready);
                end
            end
            if (t == 1) begin
                data_in = 16'h5678;
            end else if (t == 18) begin
                RST        = 1'b1;
                data_valid = 1'b1;
                data_in    = 16'hBEEF;
            end else begin
                RST        = 1'b0;
                data_valid = 1'b0;
            end
        end
        test_single_word(16'h0001);
    endtask

    task automatic test_extremes();
        logic exp;
        localparam int LAST = 2 * WORD_CYCLES + 2;
        @(negedge CLK);
        data_valid = 1'b1;
        data_in    = 16'h0000;
        for (int t = 1; t <= LAST; t++) begin
            @(negedge CLK);
            if (t >= 2) begin
                exp = (t <= LAST - 1)
                    ? exp_line(((t - 2) < WORD_CYCLES) ? 16'h0000 : 16'hFFFF, (t - 2) % WORD_CYCLES)
                    : 1'b1;
                checks++;
                if (UART_RXD_OUT !== exp) begin
                    errors++;
                    $display("FAIL ext_line t=%0d got %b want %b", t, UART_RXD_OUT, exp);
                end
            end
            if (t >= LAST - 1) begin
                exp = (t == LAST - 1);
                checks++;
                if (busy !== exp) begin
                    errors++;
                    $display("FAIL ext_busy t=%0d got %b want %b", t, busy, exp);
                end
            end
            if (t == 1) data_in = 16'hFFFF;
            else        data_valid = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single_word(16'hA5C3);
        test_backpressure();
        test_reset_midframe();
        test_extremes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
